sid_bus_master: RTL and testbench
=================================

// Module: sid_bus_master
// PURPOSE
//   Initiator side of the SID register-write bus. Accepts (voice, addr, data)
//   write commands on a valid/ready port and queues them in a small FIFO.
//   Replays each command onto the tt_um_sid write interface (ui_in / uio_in)
//   with a fixed setup / strobe / hold phase sequence.
//   Sits between a host (SPI/UART bridge or on-chip sequencer) and the SID
//   core, so no software has to bit-bang the strobe.
// PARAMETERS
//   FIFO_DEPTH    4   command queue depth; power of two, >= 2
//   SETUP_CYCLES  1   cycles addr/data are driven with wr=0 before the strobe, >= 1
//   HOLD_CYCLES   1   cycles addr/data are held with wr=0 after the strobe, >= 1
// PORTS
//   clk        in   1  system clock (24 MHz)
//   rst_n      in   1  asynchronous, active-low reset
//   cmd_valid  in   1  host presents a command
//   cmd_ready  out  1  FIFO can accept a command
//   cmd_voice  in   2  voice select; 0-2 = voices, 3 = filter/volume block
//   cmd_addr   in   3  register address within the voice
//   cmd_data   in   8  register write data
//   bus_ctrl   out  8  to ui_in: {wr, 2'b00, voice[1:0], addr[2:0]}
//   bus_data   out  8  to uio_in: write data
//   idle       out  1  FIFO empty and FSM in IDLE
//   wr_count   out  16 completed strobes, wraps modulo 2^16
// BEHAVIOUR
//   Reset (async, immediate): bus_ctrl=0, bus_data=0, FIFO empty, FSM=IDLE,
//     cmd_ready=1, idle=1, wr_count=0. A transaction in flight is abandoned.
//     The wr bit falls with rst_n, not at the next edge.
//   Push: a command is accepted on a clk edge with cmd_valid && cmd_ready.
//   cmd_ready = (count < FIFO_DEPTH), decoded from registered count only.
//     A pop in the same cycle does not raise ready (no pass-through).
//   cmd_valid while full: ignored; the command is dropped and state is unchanged.
//   FSM states:
//     IDLE   -> SETUP when the FIFO is non-empty. The pop loads bus_ctrl and
//               bus_data at that edge, with wr=0.
//     SETUP  -> held SETUP_CYCLES cycles, wr=0 -> STROBE.
//     STROBE -> exactly 1 cycle with wr=1; addr, voice and data unchanged.
//               wr_count increments on exit -> HOLD.
//     HOLD   -> held HOLD_CYCLES cycles, wr=0, addr/data unchanged. Then:
//               - FIFO non-empty: pop directly into SETUP.
//               - otherwise: IDLE.
//   Timing: accept at edge N into an empty FIFO while IDLE. The bus is valid
//     after edge N+1, and wr is high during the cycle after edge N+1+SETUP_CYCLES.
//   Back-to-back strobe period = SETUP_CYCLES + 1 + HOLD_CYCLES cycles
//     (3 at defaults).
//   IDLE: bus_ctrl[6:0] and bus_data keep the last command; wr=0.
//   Push and pop in the same cycle: count unchanged; FIFO order preserved.
//   The FIFO is strict FIFO, with no coalescing or reordering.
//   bus_ctrl[6:5] are always 0.
//   All outputs are registered; no combinational path from cmd_* to bus_*.
// STRUCTURE
//   sid_bus_pkg holds:
//     - register address localparams: FREQ_LO..WAV = 0..6,
//       FC_LO/FC_HI/RES_FILT/MODE_VOL = 0..3
//     - VOICE_FILT = 2'd3
//     - FSM state enum: IDLE, SETUP, STROBE, HOLD
//     - command struct {voice, addr, data} (13 bits)
//   Sub-module sid_cmd_fifo: synchronous FIFO with count and full/empty.
//   Top level: FSM, phase counter, output registers, wr_count.
// TESTING
//   1 Reset: hold rst_n=0 for 50 cycles.
//     -> bus_ctrl=00, bus_data=00, cmd_ready=1, idle=1, wr_count=0.
//   2 Single write, voice 0, addr 0, data 0x24.
//     -> bus_ctrl=0x00 / bus_data=0x24 for 1 cycle, then 0x80 for 1 cycle,
//        then 0x00; one wr pulse; wr_count=1; idle=1 afterwards.
//   3 Filter write, voice 3, addr 3, data 0x1F.
//     -> bus_ctrl=0x1B, then 0x9B for exactly 1 cycle, then 0x1B;
//        bus_data=0x1F throughout.
//   4 Burst: cmd_valid held high with 10 distinct commands.
//     -> cmd_ready deasserts once 4 are queued; the bus replays all 10 in order;
//        wr pulses every 3 cycles; wr_count=10.
//   5 Reset during STROBE.
//     -> wr drops asynchronously; FIFO is empty after reset; no further pulses.
//   6 Full FIFO plus an extra push with cmd_valid=1.
//     -> the extra command never appears on the bus; the count of replayed
//        writes is 4 plus those already in flight.

Source files
------------

// File: rtl/sid_bus_pkg.sv
// Shared types and register map for the SID write-bus initiator.
package sid_bus_pkg;
  localparam logic [2:0] FREQ_LO  = 3'd0;
  localparam logic [2:0] FREQ_HI  = 3'd1;
  localparam logic [2:0] PW_LO    = 3'd2;
  localparam logic [2:0] PW_HI    = 3'd3;
  localparam logic [2:0] ATK_DEC  = 3'd4;
  localparam logic [2:0] SUS_REL  = 3'd5;
  localparam logic [2:0] WAV      = 3'd6;
  localparam logic [2:0] FC_LO    = 3'd0;
  localparam logic [2:0] FC_HI    = 3'd1;
  localparam logic [2:0] RES_FILT = 3'd2;
  localparam logic [2:0] MODE_VOL = 3'd3;
  localparam logic [1:0] VOICE_FILT = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef struct packed {
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } sid_cmd_t;
endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout while non-empty.
module sid_cmd_fifo
  import sid_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  sid_cmd_t                 din,
  output sid_cmd_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  sid_cmd_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sid_bus_master.sv
// Queues host register writes and replays them onto the SID bus with a
// setup / strobe / hold sequence.
module sid_bus_master
  import sid_bus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_voice,
  input  logic [2:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  bus_ctrl,
  output logic [7:0]  bus_data,
  output logic        idle,
  output logic [15:0] wr_count
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int MAXP = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int PW   = $clog2(MAXP + 1);

  state_t         state;
  logic [PW-1:0]  phase;
  logic [CW-1:0]  fifo_count;
  logic           empty, push, pop, last_setup, last_hold;
  sid_cmd_t       head, din;

  assign din        = '{voice: cmd_voice, addr: cmd_addr, data: cmd_data};
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign cmd_ready  = (fifo_count < CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign last_setup = (phase == PW'(SETUP_CYCLES - 1));
  assign last_hold  = (phase == PW'(HOLD_CYCLES - 1));
  assign pop        = !empty && ((state == IDLE) || (state == HOLD && last_hold));
  assign idle       = empty && (state == IDLE);

  sid_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (fifo_count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      bus_ctrl <= '0;
      bus_data <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SETUP;
            phase    <= '0;
            bus_ctrl <= {3'b000, head.voice, head.addr};
            bus_data <= head.data;
          end
        end
        SETUP: begin
          if (last_setup) begin
            state       <= STROBE;
            phase       <= '0;
            bus_ctrl[7] <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        STROBE: begin
          state       <= HOLD;
          phase       <= '0;
          bus_ctrl[7] <= 1'b0;
          wr_count    <= wr_count + 16'd1;
        end
        HOLD: begin
          if (!last_hold) begin
            phase <= phase + 1'b1;
          end else if (pop) begin
            state    <= SETUP;
            phase    <= '0;
            bus_ctrl <= {3'b000, head.voice, head.addr};
            bus_data <= head.data;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sid_bus_master.sv
// Randomized bench for sid_bus_master: accepted commands are checked against
// the strobes seen on the bus, in order and with the expected cadence.
module tb_sid_bus_master;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_voice = 0;
  logic [2:0]  cmd_addr = 0;
  logic [7:0]  cmd_data = 0;
  logic [7:0]  bus_ctrl, bus_data;
  logic        idle;
  logic [15:0] wr_count;

  int checks = 0, failures = 0;
  int cyc = 0;
  int exp_wr = 0;

  typedef struct { int cyc; logic [7:0] ctrl; logic [7:0] data; } strobe_t;
  typedef struct { logic [1:0] v; logic [2:0] a; logic [7:0] d; } cmd_t;
  strobe_t obs_q[$];
  cmd_t    exp_q[$];

  sid_bus_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_voice(cmd_voice), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .bus_ctrl(bus_ctrl), .bus_data(bus_data), .idle(idle), .wr_count(wr_count)
  );

  always #20.833 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n && bus_ctrl[7]) obs_q.push_back('{cyc, bus_ctrl, bus_data});

  // Called at a negedge; ready there equals ready at the following edge.
  task automatic send(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d, output bit ok);
    ok = 0;
    cmd_valid = 1; cmd_voice = v; cmd_addr = a; cmd_data = d;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (cmd_ready) ok = 1;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL send_accept: ready never seen, required within 64 cycles"); end
    else begin exp_q.push_back('{v, a, d}); exp_wr++; end
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (idle) done = 1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!done) begin failures++; $display("FAIL %s_idle: idle=%b, required 1 within 300 cycles", name, idle); end
  endtask

  // Compare every observed strobe against the accepted command stream.
  task automatic check_replay(input string name, input bit check_period);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: strobes=%0d, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].ctrl !== {3'b100, exp_q[i].v, exp_q[i].a} || obs_q[i].data !== exp_q[i].d) begin
        failures++;
        $display("FAIL %s_order[%0d]: ctrl=%h data=%h, required ctrl=%h data=%h", name, i,
                 obs_q[i].ctrl, obs_q[i].data, {3'b100, exp_q[i].v, exp_q[i].a}, exp_q[i].d);
      end
      if (check_period && i > 0) begin
        checks++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 3) begin
          failures++;
          $display("FAIL %s_period[%0d]: gap=%0d, required 3", name, i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      failures++; $display("FAIL %s_wr_count: got %0d, required %0d", name, wr_count, exp_wr);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (50) @(negedge clk);
    checks += 5;
    if (bus_ctrl !== 8'h00) begin failures++; $display("FAIL reset_ctrl: got %h, required 00", bus_ctrl); end
    if (bus_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h, required 00", bus_data); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
    if (idle !== 1'b1)      begin failures++; $display("FAIL reset_idle: got %b, required 1", idle); end
    if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count: got %0d, required 0", wr_count); end
    rst_n = 1;
    exp_wr = 0;
    @(negedge clk);
  endtask

  task automatic trace(input string name, input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
    bit ok;
    logic [7:0] base;
    logic [7:0] exp_ctrl [3];
    base = {3'b000, v, a};
    exp_ctrl[0] = base; exp_ctrl[1] = base | 8'h80; exp_ctrl[2] = base;
    obs_q.delete(); exp_q.delete();
    send(v, a, d, ok);
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_ctrl !== exp_ctrl[i] || bus_data !== d) begin
        failures++;
        $display("FAIL %s_trace[%0d]: ctrl=%h data=%h, required ctrl=%h data=%h",
                 name, i, bus_ctrl, bus_data, exp_ctrl[i], d);
      end
    end
    wait_idle(name);
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL %s_pulses: got %0d, required 1", name, obs_q.size()); end
    checks++;
    if (wr_count !== 16'(exp_wr)) begin failures++; $display("FAIL %s_wr_count: got %0d, required %0d", name, wr_count, exp_wr); end
  endtask

  task automatic test_single(); trace("single", 2'd0, 3'd0, 8'h24); endtask
  task automatic test_filter(); trace("filter", 2'd3, 3'd3, 8'h1F); endtask

  task automatic test_burst();
    bit ok, saw_full = 0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), {4'(i), 4'($urandom_range(0, 15))}, ok);
      if (!cmd_ready) saw_full = 1;
    end
    cmd_valid = 0;
    wait_idle("burst");
    checks++;
    if (!saw_full) begin failures++; $display("FAIL burst_ready_drop: ready stayed 1, required a drop"); end
    check_replay("burst", 1);
  endtask

  task automatic test_back_to_back_random();
    bit ok;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom), ok);
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    cmd_valid = 0;
    wait_idle("random");
    check_replay("random", 0);
  endtask

  task automatic test_reset_strobe();
    bit ok, hit = 0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) send(2'(i), 3'(i), 8'h40 + 8'(i), ok);
    cmd_valid = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      if (bus_ctrl[7]) hit = 1; else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_strobe_seen: wr never high, required high"); end
    #2 rst_n = 0;
    #1;
    checks += 4;
    if (bus_ctrl !== 8'h00) begin failures++; $display("FAIL rst_async_ctrl: got %h, required 00", bus_ctrl); end
    if (idle !== 1'b1)      begin failures++; $display("FAIL rst_async_idle: got %b, required 1", idle); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready: got %b, required 1", cmd_ready); end
    if (wr_count !== 16'd0) begin failures++; $display("FAIL rst_async_wr_count: got %0d, required 0", wr_count); end
    @(negedge clk);
    rst_n = 1;
    exp_wr = 0;
    obs_q.delete(); exp_q.delete();
    repeat (20) @(negedge clk);
    checks += 2;
    if (obs_q.size() != 0)  begin failures++; $display("FAIL rst_no_pulses: got %0d, required 0", obs_q.size()); end
    if (wr_count !== 16'd0) begin failures++; $display("FAIL rst_after_wr_count: got %0d, required 0", wr_count); end
  endtask

  task automatic test_full_drop();
    bit ok, dropped_seen = 0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8 && !dropped_seen; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 127)), ok);
      if (!cmd_ready) begin
        cmd_voice = 2'd1; cmd_addr = 3'd7; cmd_data = 8'hEE;
        @(negedge clk);
        dropped_seen = 1;
      end
    end
    cmd_valid = 0;
    wait_idle("full");
    checks++;
    if (!dropped_seen || exp_q.size() < 5) begin
      failures++; $display("FAIL full_reached: accepted=%0d, required >= 5 with a full FIFO", exp_q.size());
    end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i].data === 8'hEE) begin failures++; $display("FAIL full_dropped[%0d]: data=%h, required not EE", i, obs_q[i].data); end
    end
    check_replay("full", 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_burst();
    test_back_to_back_random();
    test_reset_strobe();
    test_full_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
